// File: rtl/chinpo_pkg.sv
// Shared definitions for the CHINPO multicycle control unit: state codes,
// opcode constants, ALU operation codes and ALU operand-B select codes.
package chinpo_pkg;

   // State codes. They are visible on the debug ports, so the values are fixed.
   // Code 15 is not used and is treated as a corrupted state.
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_DR       = 4'd2,
      ST_I        = 4'd3,
      ST_ADDR     = 4'd4,
      ST_BEQ      = 4'd5,
      ST_J        = 4'd6,
      ST_JR       = 4'd7,
      ST_WB       = 4'd8,
      ST_SW_WRITE = 4'd9,
      ST_LW_READ  = 4'd10,
      ST_LW_WRITE = 4'd11,
      ST_JAL      = 4'd12,
      ST_RESET    = 4'd13,
      ST_FAULT    = 4'd14
   } state_t;

   // Opcodes that get special handling. The opcode is taken from its low 4 bits.
   localparam logic [3:0] OP_JR  = 4'd3;
   localparam logic [3:0] OP_J   = 4'd8;
   localparam logic [3:0] OP_JAL = 4'd11;
   localparam logic [3:0] OP_BEQ = 4'd12;
   localparam logic [3:0] OP_LW  = 4'd14;
   localparam logic [3:0] OP_SW  = 4'd15;

   // ALU operation codes
   localparam logic [1:0] ALU_ADD  = 2'd0;
   localparam logic [1:0] ALU_FUNC = 2'd2;
   localparam logic [1:0] ALU_PASS = 2'd3;

   // ALU operand-B select codes
   localparam logic [2:0] SRCB_REG  = 3'd0;
   localparam logic [2:0] SRCB_IMM  = 3'd1;
   localparam logic [2:0] SRCB_OFFS = 3'd3;
   localparam logic [2:0] SRCB_FOUR = 3'd4;

   // States that wait on the memory handshake
   function automatic logic is_mem_wait_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_SW_WRITE) || (s == ST_LW_READ);
   endfunction

endpackage

// File: rtl/chinpo_wait_timer.sv
// Counts consecutive cycles in which memory is not ready.
// It raises the timeout flag when the budget is used up and memory is still
// not ready.
module chinpo_wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_count_en,
   input  logic i_clear,
   input  logic i_mem_ready,
   output logic o_timeout
);

   localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

   logic [CW-1:0] r_count;

   // Count wait cycles. Clear on a state change. Stop at the limit so the
   // count cannot wrap when the timeout is disabled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_count_en && (r_count != LIMIT)) begin
         r_count <= r_count + CW'(1);
      end
   end

   // A ready memory always beats the timeout in the same cycle.
   // MAX_WAIT of 0 disables the timeout.
   assign o_timeout = (MAX_WAIT != 0) && (r_count == LIMIT) && !i_mem_ready;

endmodule

// File: rtl/chinpo_mc_control.sv
// CHINPO multicycle control FSM. It adds a memory handshake with a timeout,
// fetch stall, illegal-opcode trapping and an instruction-retire strobe.
// Outputs are decoded combinationally from the registered state.
module chinpo_mc_control
   import chinpo_pkg::*;
#(
   parameter int OPW      = 4,
   parameter int MAX_WAIT = 15
) (
   input  logic           CLK,
   input  logic           Reset,
   input  logic [OPW-1:0] Opcode,
   input  logic           Branch,
   input  logic [3:0]     IR,
   input  logic           MemReady,
   input  logic           Stall,
   output logic           PCWrite,
   output logic           IRWrite,
   output logic           RegWrite,
   output logic           MemRead,
   output logic           MemWrite,
   output logic           MemAddr,
   output logic           PcIn,
   output logic           ALUSrcA,
   output logic           WriteDataSrc,
   output logic           MVA,
   output logic           MVB,
   output logic           CLRA,
   output logic           CLRB,
   output logic [2:0]     ALUSrcB,
   output logic [1:0]     ALUOp,
   output logic           InstrDone,
   output logic           Fault,
   output logic [3:0]     current_state,
   output logic [3:0]     next_state
);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] w_op;
   logic       w_illegal;
   logic       w_is_sw;
   logic       w_is_jal;
   logic       w_timeout;
   logic       w_cnt_en;
   logic       w_cnt_clear;

   assign w_op = Opcode[3:0];

   // Any opcode with a set bit at position 4 or above has no instruction.
   generate
      if (OPW > 4) begin : g_wide_op
         assign w_illegal = |Opcode[OPW-1:4];
      end else begin : g_narrow_op
         assign w_illegal = 1'b0;
      end
   endgenerate

   assign w_is_sw  = !w_illegal && (w_op == OP_SW);
   assign w_is_jal = !w_illegal && (w_op == OP_JAL);

   // Count not-ready cycles in the memory states. A FETCH cycle held only by
   // Stall with memory ready does not count.
   assign w_cnt_en    = is_mem_wait_state(r_state) && !MemReady;
   assign w_cnt_clear = (w_next != r_state);

   chinpo_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .i_clk       (CLK),
      .i_rst       (Reset),
      .i_count_en  (w_cnt_en),
      .i_clear     (w_cnt_clear),
      .i_mem_ready (MemReady),
      .o_timeout   (w_timeout)
   );

   // State register. Reset takes effect immediately and abandons any memory access.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_RESET;
      end else begin
         r_state <= w_next;
      end
   end

   // Decode the next state and all control outputs from the current state and inputs.
   always_comb begin
      w_next       = r_state;
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      MemAddr      = 1'b0;
      PcIn         = 1'b0;
      ALUSrcA      = 1'b0;
      WriteDataSrc = 1'b0;
      MVA          = 1'b0;
      MVB          = 1'b0;
      CLRA         = 1'b0;
      CLRB         = 1'b0;
      ALUSrcB      = SRCB_REG;
      ALUOp        = ALU_ADD;
      InstrDone    = 1'b0;
      Fault        = 1'b0;

      case (r_state)
         ST_RESET: begin
            w_next = ST_FETCH;
         end
         ST_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            ALUOp   = ALU_ADD;
            if (MemReady && !Stall) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               w_next  = ST_DECODE;
            end else if (w_timeout) begin
               w_next = ST_FAULT;
            end
         end
         ST_DECODE: begin
            ALUSrcB = SRCB_OFFS;
            ALUOp   = ALU_ADD;
            if (w_illegal) begin
               w_next = ST_FAULT;
            end else begin
               case (w_op)
                  OP_JR:                          w_next = ST_JR;
                  4'd4, 4'd9, 4'd10, 4'd13:       w_next = ST_I;
                  4'd0, 4'd1, 4'd2, 4'd5, 4'd6,
                  4'd7:                           w_next = ST_DR;
                  OP_J, OP_JAL:                   w_next = ST_J;
                  OP_LW, OP_SW:                   w_next = ST_ADDR;
                  OP_BEQ: begin
                     if (Branch) begin
                        w_next = ST_BEQ;
                     end else begin
                        w_next    = ST_FETCH;
                        InstrDone = 1'b1;
                     end
                  end
                  default:                        w_next = ST_FAULT;
               endcase
            end
         end
         ST_DR: begin
            ALUOp   = ALU_FUNC;
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_REG;
            {MVA, MVB, CLRA, CLRB} = IR;
            w_next  = ST_WB;
         end
         ST_I: begin
            ALUOp   = ALU_FUNC;
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            w_next  = ST_WB;
         end
         ST_ADDR: begin
            ALUOp   = ALU_ADD;
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_OFFS;
            w_next  = w_is_sw ? ST_SW_WRITE : ST_LW_READ;
         end
         ST_BEQ: begin
            PCWrite   = 1'b1;
            InstrDone = 1'b1;
            w_next    = ST_FETCH;
         end
         ST_JR: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_PASS;
            {MVA, MVB, CLRA, CLRB} = IR;
            w_next  = ST_J;
         end
         ST_J: begin
            PCWrite = 1'b1;
            PcIn    = 1'b1;
            ALUOp   = ALU_PASS;
            if (w_is_jal) begin
               w_next = ST_JAL;
            end else begin
               w_next    = ST_FETCH;
               InstrDone = 1'b1;
            end
         end
         ST_WB, ST_JAL: begin
            RegWrite     = 1'b1;
            WriteDataSrc = 1'b0;
            InstrDone    = 1'b1;
            w_next       = ST_FETCH;
         end
         ST_SW_WRITE: begin
            MemAddr   = 1'b1;
            MemWrite  = 1'b1;
            InstrDone = MemReady;
            if (MemReady) begin
               w_next = ST_FETCH;
            end else if (w_timeout) begin
               w_next = ST_FAULT;
            end
         end
         ST_LW_READ: begin
            MemAddr = 1'b1;
            MemRead = 1'b1;
            if (MemReady) begin
               w_next = ST_LW_WRITE;
            end else if (w_timeout) begin
               w_next = ST_FAULT;
            end
         end
         ST_LW_WRITE: begin
            RegWrite     = 1'b1;
            WriteDataSrc = 1'b1;
            InstrDone    = 1'b1;
            w_next       = ST_FETCH;
         end
         ST_FAULT: begin
            Fault  = 1'b1;
            w_next = ST_FAULT;
         end
         default: begin
            w_next = ST_FAULT;
         end
      endcase
   end

   assign current_state = r_state;
   assign next_state    = w_next;

endmodule

// File: tb/tb_chinpo_mc_control.sv
// Directed testbench for chinpo_mc_control. It drives a table of per-cycle
// instruction traces with expected state and control words. Short hand-written
// sequences cover timeouts, stalls and illegal opcodes.
module tb_chinpo_mc_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opc;
   logic       br;
   logic [3:0] ir;
   logic       mr;
   logic       st;

   always #5 clk = ~clk;

   // Instance A: OPW=4, MAX_WAIT=15
   logic a_pcw, a_irw, a_rw, a_mr, a_mw, a_ma, a_pcin, a_asa, a_wds;
   logic a_mva, a_mvb, a_clra, a_clrb, a_done, a_fault;
   logic [2:0] a_asb;
   logic [1:0] a_aop;
   logic [3:0] a_cur, a_nxt;

   // Instance B: OPW=6, MAX_WAIT=4
   logic b_pcw, b_irw, b_rw, b_mr, b_mw, b_ma, b_pcin, b_asa, b_wds;
   logic b_mva, b_mvb, b_clra, b_clrb, b_done, b_fault;
   logic [2:0] b_asb;
   logic [1:0] b_aop;
   logic [3:0] b_cur, b_nxt;

   chinpo_mc_control #(.OPW(4), .MAX_WAIT(15)) dut_a (
      .CLK(clk), .Reset(rst), .Opcode(opc[3:0]), .Branch(br), .IR(ir),
      .MemReady(mr), .Stall(st),
      .PCWrite(a_pcw), .IRWrite(a_irw), .RegWrite(a_rw), .MemRead(a_mr),
      .MemWrite(a_mw), .MemAddr(a_ma), .PcIn(a_pcin), .ALUSrcA(a_asa),
      .WriteDataSrc(a_wds), .MVA(a_mva), .MVB(a_mvb), .CLRA(a_clra),
      .CLRB(a_clrb), .ALUSrcB(a_asb), .ALUOp(a_aop), .InstrDone(a_done),
      .Fault(a_fault), .current_state(a_cur), .next_state(a_nxt)
   );

   chinpo_mc_control #(.OPW(6), .MAX_WAIT(4)) dut_b (
      .CLK(clk), .Reset(rst), .Opcode(opc), .Branch(br), .IR(ir),
      .MemReady(mr), .Stall(st),
      .PCWrite(b_pcw), .IRWrite(b_irw), .RegWrite(b_rw), .MemRead(b_mr),
      .MemWrite(b_mw), .MemAddr(b_ma), .PcIn(b_pcin), .ALUSrcA(b_asa),
      .WriteDataSrc(b_wds), .MVA(b_mva), .MVB(b_mvb), .CLRA(b_clra),
      .CLRB(b_clrb), .ALUSrcB(b_asb), .ALUOp(b_aop), .InstrDone(b_done),
      .Fault(b_fault), .current_state(b_cur), .next_state(b_nxt)
   );

   logic [19:0] a_ctl;
   assign a_ctl = {a_pcw, a_irw, a_rw, a_mr, a_mw, a_ma, a_pcin, a_asa, a_wds,
                   a_mva, a_mvb, a_clra, a_clrb, a_asb, a_aop, a_done, a_fault};

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0]  op;
      logic        br;
      logic [3:0]  ir;
      logic        mr;
      logic        st;
      logic [3:0]  cur;
      logic [3:0]  nxt;
      logic [19:0] ctl;
   } vec_t;

   vec_t vecs[$];

   // Packs a control word in the same field order as a_ctl
   function automatic logic [19:0] ctl(
      input logic pcw, input logic irw, input logic rw, input logic mrd,
      input logic mw, input logic ma, input logic pcin, input logic asa,
      input logic wds, input logic [3:0] irb, input logic [2:0] asb,
      input logic [1:0] aop, input logic dn, input logic flt);
      return {pcw, irw, rw, mrd, mw, ma, pcin, asa, wds, irb, asb, aop, dn, flt};
   endfunction

   task automatic add(input logic [5:0] op, input logic b, input logic [3:0] i,
                      input logic m, input logic s, input logic [3:0] c,
                      input logic [3:0] n, input logic [19:0] k);
      vec_t v;
      v.op = op; v.br = b; v.ir = i; v.mr = m; v.st = s;
      v.cur = c; v.nxt = n; v.ctl = k;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [19:0] c_zero, c_fetch_go, c_fetch_hold, c_decode, c_decode_done;
   logic [19:0] c_dr_1010, c_i, c_wb, c_beq, c_j_mid, c_j_end, c_jr_1010;
   logic [19:0] c_addr, c_sw_done, c_lr, c_lw;

   initial begin
      c_zero        = 20'h0;
      c_fetch_go    = ctl(1,1,0,1,0,0,0,0,0,4'b0000,3'd4,2'd0,0,0);
      c_fetch_hold  = ctl(0,0,0,1,0,0,0,0,0,4'b0000,3'd4,2'd0,0,0);
      c_decode      = ctl(0,0,0,0,0,0,0,0,0,4'b0000,3'd3,2'd0,0,0);
      c_decode_done = ctl(0,0,0,0,0,0,0,0,0,4'b0000,3'd3,2'd0,1,0);
      c_dr_1010     = ctl(0,0,0,0,0,0,0,1,0,4'b1010,3'd0,2'd2,0,0);
      c_i           = ctl(0,0,0,0,0,0,0,1,0,4'b0000,3'd1,2'd2,0,0);
      c_wb          = ctl(0,0,1,0,0,0,0,0,0,4'b0000,3'd0,2'd0,1,0);
      c_beq         = ctl(1,0,0,0,0,0,0,0,0,4'b0000,3'd0,2'd0,1,0);
      c_j_mid       = ctl(1,0,0,0,0,0,1,0,0,4'b0000,3'd0,2'd3,0,0);
      c_j_end       = ctl(1,0,0,0,0,0,1,0,0,4'b0000,3'd0,2'd3,1,0);
      c_jr_1010     = ctl(0,0,0,0,0,0,0,1,0,4'b1010,3'd0,2'd3,0,0);
      c_addr        = ctl(0,0,0,0,0,0,0,1,0,4'b0000,3'd3,2'd0,0,0);
      c_sw_done     = ctl(0,0,0,0,1,1,0,0,0,4'b0000,3'd0,2'd0,1,0);
      c_lr          = ctl(0,0,0,1,0,1,0,0,0,4'b0000,3'd0,2'd0,0,0);
      c_lw          = ctl(0,0,1,0,0,0,0,0,1,4'b0000,3'd0,2'd0,1,0);

      // One row per cycle: op, br, ir, mr, st, cur, next, control word
      // DR instruction (opcode 2) starting from RESET
      add(6'd2, 0, 4'b1010, 1, 0, 4'd13, 4'd0,  c_zero);
      add(6'd2, 0, 4'b1010, 1, 0, 4'd0,  4'd1,  c_fetch_go);
      add(6'd2, 0, 4'b1010, 1, 0, 4'd1,  4'd2,  c_decode);
      add(6'd2, 0, 4'b1010, 1, 0, 4'd2,  4'd8,  c_dr_1010);
      add(6'd2, 0, 4'b1010, 1, 0, 4'd8,  4'd0,  c_wb);
      // BEQ taken
      add(6'd12, 1, 4'b0000, 1, 0, 4'd0, 4'd1,  c_fetch_go);
      add(6'd12, 1, 4'b0000, 1, 0, 4'd1, 4'd5,  c_decode);
      add(6'd12, 1, 4'b0000, 1, 0, 4'd5, 4'd0,  c_beq);
      // BEQ not taken
      add(6'd12, 0, 4'b0000, 1, 0, 4'd0, 4'd1,  c_fetch_go);
      add(6'd12, 0, 4'b0000, 1, 0, 4'd1, 4'd0,  c_decode_done);
      // I-type (opcode 4)
      add(6'd4, 0, 4'b0000, 1, 0, 4'd0, 4'd1,   c_fetch_go);
      add(6'd4, 0, 4'b0000, 1, 0, 4'd1, 4'd3,   c_decode);
      add(6'd4, 0, 4'b0000, 1, 0, 4'd3, 4'd8,   c_i);
      add(6'd4, 0, 4'b0000, 1, 0, 4'd8, 4'd0,   c_wb);
      // JAL (opcode 11)
      add(6'd11, 0, 4'b0000, 1, 0, 4'd0, 4'd1,  c_fetch_go);
      add(6'd11, 0, 4'b0000, 1, 0, 4'd1, 4'd6,  c_decode);
      add(6'd11, 0, 4'b0000, 1, 0, 4'd6, 4'd12, c_j_mid);
      add(6'd11, 0, 4'b0000, 1, 0, 4'd12, 4'd0, c_wb);
      // JR (opcode 3)
      add(6'd3, 0, 4'b1010, 1, 0, 4'd0, 4'd1,   c_fetch_go);
      add(6'd3, 0, 4'b1010, 1, 0, 4'd1, 4'd7,   c_decode);
      add(6'd3, 0, 4'b1010, 1, 0, 4'd7, 4'd6,   c_jr_1010);
      add(6'd3, 0, 4'b1010, 1, 0, 4'd6, 4'd0,   c_j_end);
      // Store, zero wait
      add(6'd15, 0, 4'b0000, 1, 0, 4'd0, 4'd1,  c_fetch_go);
      add(6'd15, 0, 4'b0000, 1, 0, 4'd1, 4'd4,  c_decode);
      add(6'd15, 0, 4'b0000, 1, 0, 4'd4, 4'd9,  c_addr);
      add(6'd15, 0, 4'b0000, 1, 0, 4'd9, 4'd0,  c_sw_done);
      // Load with three not-ready cycles
      add(6'd14, 0, 4'b0000, 1, 0, 4'd0, 4'd1,  c_fetch_go);
      add(6'd14, 0, 4'b0000, 1, 0, 4'd1, 4'd4,  c_decode);
      add(6'd14, 0, 4'b0000, 1, 0, 4'd4, 4'd10, c_addr);
      add(6'd14, 0, 4'b0000, 0, 0, 4'd10, 4'd10, c_lr);
      add(6'd14, 0, 4'b0000, 0, 0, 4'd10, 4'd10, c_lr);
      add(6'd14, 0, 4'b0000, 0, 0, 4'd10, 4'd10, c_lr);
      add(6'd14, 0, 4'b0000, 1, 0, 4'd10, 4'd11, c_lr);
      add(6'd14, 0, 4'b0000, 1, 0, 4'd11, 4'd0,  c_lw);
      // Stalled fetch for two cycles, then J (opcode 8)
      add(6'd8, 0, 4'b0000, 1, 1, 4'd0, 4'd0,   c_fetch_hold);
      add(6'd8, 0, 4'b0000, 1, 1, 4'd0, 4'd0,   c_fetch_hold);
      add(6'd8, 0, 4'b0000, 1, 0, 4'd0, 4'd1,   c_fetch_go);
      add(6'd8, 0, 4'b0000, 1, 0, 4'd1, 4'd6,   c_decode);
      add(6'd8, 0, 4'b0000, 1, 0, 4'd6, 4'd0,   c_j_end);
      // Fetch with one not-ready cycle
      add(6'd8, 0, 4'b0000, 0, 0, 4'd0, 4'd0,   c_fetch_hold);
      add(6'd8, 0, 4'b0000, 1, 0, 4'd0, 4'd1,   c_fetch_go);

      // Reset state
      rst = 1'b1; opc = 6'd14; br = 1'b0; ir = 4'b0000; mr = 1'b1; st = 1'b0;
      tick();
      chk("reset_state_a", {28'd0, a_cur}, 32'd13);
      chk("reset_ctl_a", {12'd0, a_ctl}, 32'd0);
      chk("reset_state_b", {28'd0, b_cur}, 32'd13);

      // Run a load into LW_READ, then reset it mid-access
      rst = 1'b0;
      tick(); tick(); tick(); tick();
      mr = 1'b0;
      #1;
      chk("lwread_reached", {28'd0, a_cur}, 32'd10);
      tick();
      #2 rst = 1'b1;
      #1;
      chk("async_reset_state", {28'd0, a_cur}, 32'd13);
      chk("async_reset_nowrite", {30'd0, a_rw, a_mw}, 32'd0);
      tick();
      rst = 1'b0;

      // Table-driven traces on instance A
      for (int v = 0; v < vecs.size(); v++) begin
         opc = vecs[v].op; br = vecs[v].br; ir = vecs[v].ir;
         mr = vecs[v].mr; st = vecs[v].st;
         #1;
         $display("vec %0d op %0d state %0d next %0d ctl %05h", v, vecs[v].op,
                  a_cur, a_nxt, a_ctl);
         chk($sformatf("vec%0d", v), {4'd0, a_cur, a_nxt, a_ctl},
             {4'd0, vecs[v].cur, vecs[v].nxt, vecs[v].ctl});
         tick();
      end

      // Store timeout on instance B (MAX_WAIT=4): five SW_WRITE cycles, then FAULT
      rst = 1'b1; opc = 6'd15; ir = 4'b0000; br = 1'b0; mr = 1'b1; st = 1'b0;
      tick();
      rst = 1'b0;
      tick(); tick(); tick(); tick();
      mr = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         $display("sw wait %0d state %0d next %0d", k, b_cur, b_nxt);
         chk($sformatf("sw_wait%0d", k), {26'd0, b_cur, b_mw, b_ma},
             {26'd0, 4'd9, 1'b1, 1'b1});
         chk($sformatf("sw_next%0d", k), {28'd0, b_nxt}, (k < 4) ? 32'd9 : 32'd14);
         tick();
      end
      chk("sw_fault", {26'd0, b_cur, b_fault, b_mw}, {26'd0, 4'd14, 1'b1, 1'b0});
      mr = 1'b1;
      tick(); tick(); tick();
      chk("fault_sticky", {26'd0, b_cur, b_fault, b_done}, {26'd0, 4'd14, 1'b1, 1'b0});
      rst = 1'b1;
      #1;
      chk("fault_cleared", {27'd0, b_cur, b_fault}, {27'd0, 4'd13, 1'b0});
      tick();
      rst = 1'b0;

      // Illegal opcode 20 on the 6-bit instance
      opc = 6'd20;
      tick(); tick();
      chk("illegal_next", {28'd0, b_cur, b_nxt}, {24'd0, 4'd1, 4'd14});
      tick();
      chk("illegal_fault", {27'd0, b_cur, b_fault}, {27'd0, 4'd14, 1'b1});

      // JR then J on the 6-bit instance with IR=1010
      rst = 1'b1; tick(); rst = 1'b0;
      opc = 6'd3; ir = 4'b1010;
      tick(); tick();
      chk("jr_decode", {28'd0, b_nxt}, 32'd7);
      tick();
      chk("jr_moves", {24'd0, b_cur, b_mva, b_mvb, b_clra, b_clrb},
          {24'd0, 4'd7, 4'b1010});
      tick();
      chk("j_after_jr", {23'd0, b_cur, b_pcin, b_pcw, b_done, b_nxt},
          {23'd0, 4'd6, 1'b1, 1'b1, 1'b1, 4'd0});

      // MemReady wins over the timeout in FETCH
      rst = 1'b1; tick(); rst = 1'b0; ir = 4'b0000; opc = 6'd2;
      tick();
      mr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("fetch_wait%0d", k), {28'd0, b_nxt}, 32'd0);
         tick();
      end
      mr = 1'b1;
      #1;
      chk("ready_beats_timeout", {28'd0, b_nxt}, 32'd1);
      tick();

      // Stall does not stop the timeout. Stalled-but-ready cycles hold the count.
      rst = 1'b1; tick(); rst = 1'b0;
      tick();
      mr = 1'b0; st = 1'b1;
      tick(); tick(); tick();
      mr = 1'b1;
      #1;
      chk("stall_hold_pulse", {29'd0, b_pcw, b_irw, b_nxt == 4'd0}, 32'd1);
      tick(); tick();
      mr = 1'b0; st = 1'b0;
      #1;
      chk("stall_count_nofault", {28'd0, b_nxt}, 32'd0);
      tick();
      chk("stall_count_timeout", {28'd0, b_nxt}, 32'd14);
      tick();
      chk("fetch_fault", {27'd0, b_cur, b_fault}, {27'd0, 4'd14, 1'b1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chinpo_mc_control.md
# chinpo_mc_control

Parametrised multicycle control unit for the CHINPO datapath; the next generation of the processor's control FSM. Adds a memory handshake: fetch, load and store wait on `MemReady` with a bounded timeout. Also adds fetch stall, illegal-opcode detection, a sticky fault state and an instruction-retire strobe. It sits between the instruction register / branch comparator and the datapath muxes, register file and memory port.

## Interface
- `OPW`, 4: opcode width. Must be ≥4; any opcode ≥16 is illegal.
- `MAX_WAIT`, 15: consecutive not-ready memory cycles tolerated before fault. 0 disables the timeout.
- `CLK` input 1: clock, rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `Opcode` input OPW: instruction opcode.
- `Branch` input 1: branch condition true.
- `IR` input 4: mode bits; IR[3]=MVA, IR[2]=MVB, IR[1]=CLRA, IR[0]=CLRB.
- `MemReady` input 1: memory completes the current access this cycle.
- `Stall` input 1: hazard hold, honoured in FETCH only.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemRead`, `MemWrite`, `MemAddr`, `PcIn`, `ALUSrcA`, `WriteDataSrc` output 1 each: datapath strobes and mux selects.
- `MVA`, `MVB`, `CLRA`, `CLRB` output 1 each: operand move/clear.
- `ALUSrcB` output 3, `ALUOp` output 2: ALU selects.
- `InstrDone` output 1: one-cycle pulse in the last state of each instruction.
- `Fault` output 1: high while in FAULT.
- `current_state`, `next_state` output 4: debug.

## Operation
- State encoding:
  - RESET=13, FETCH=0, DECODE=1, DR=2, I=3, ADDR=4, BEQ=5, J=6, JR=7, WB=8, SW_WRITE=9, LW_READ=10, LW_WRITE=11, JAL=12, FAULT=14.
  - 15 is unused and goes to FAULT.
- Default values, every state: all outputs 0 unless listed below. There are no latched mux selects.
- RESET: all outputs 0. Next state FETCH.
- FETCH:
  - Outputs: MemRead=1, ALUSrcB=4, ALUOp=0.
  - IRWrite=PCWrite=MemReady&!Stall.
  - Transition: if MemReady&!Stall, go to DECODE; otherwise stay.
- DECODE:
  - Outputs: ALUSrcB=3, ALUOp=0.
  - Opcode ≥16 goes to FAULT.
  - Opcode 3 goes to JR.
  - Opcodes 4, 9, 10, 13 go to I.
  - Opcodes 0–2, 5–7 go to DR.
  - Opcodes 8, 11 go to J.
  - Opcodes 14, 15 go to ADDR.
  - Opcode 12 goes to BEQ if Branch, else FETCH with InstrDone=1.
- DR: ALUOp=2, ALUSrcA=1, ALUSrcB=0, {MVA,MVB,CLRA,CLRB}=IR. Next state WB.
- I: ALUOp=2, ALUSrcA=1, ALUSrcB=1. Next state WB.
- ADDR: ALUOp=0, ALUSrcA=1, ALUSrcB=3. Opcode 15 goes to SW_WRITE; otherwise LW_READ.
- BEQ: PCWrite=1, InstrDone=1. Next state FETCH.
- JR: ALUSrcA=1, ALUOp=3, {MVA,MVB,CLRA,CLRB}=IR. Next state J.
- J: PCWrite=1, PcIn=1, ALUOp=3. Opcode 11 goes to JAL; otherwise FETCH with InstrDone=1.
- WB, JAL: RegWrite=1, WriteDataSrc=0, InstrDone=1. Next state FETCH.
- SW_WRITE:
  - Outputs: MemAddr=1, MemWrite=1, InstrDone=MemReady.
  - Transition: if MemReady, go to FETCH; otherwise stay.
- LW_READ: MemAddr=1, MemRead=1. If MemReady, go to LW_WRITE; otherwise stay.
- LW_WRITE: RegWrite=1, WriteDataSrc=1, InstrDone=1. Next state FETCH.
- FAULT: Fault=1, all strobes 0. Stays in FAULT until Reset.
- Wait counter:
  - Width is clog2(MAX_WAIT+1).
  - Increments each cycle spent in FETCH, SW_WRITE or LW_READ with MemReady=0.
  - A FETCH cycle held by Stall with MemReady=1 does not count.
  - Clears on any state change and on Reset.
  - When it equals MAX_WAIT and MemReady=0, next state is FAULT (only if MAX_WAIT≠0).
- Precedence when events coincide:
  - MemReady wins over timeout in the same cycle.
  - Stall does not stop the timeout in FETCH.

## Timing
- current_state is registered; outputs and next_state are combinational from current_state plus Opcode, Branch, IR, MemReady and Stall.
- Reset is asynchronous: current_state=RESET and counter=0 immediately. Any in-progress access is abandoned with no write strobe.
- Zero-wait latencies (MemReady constantly 1, Stall 0):
  - DR/I: 4 cycles (FETCH, DECODE, DR/I, WB).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - BEQ taken: 3 cycles.
  - BEQ not taken: 2 cycles.
  - J: 3 cycles.
  - JAL: 4 cycles.
  - JR: 4 cycles.
- Each not-ready or stalled cycle adds one cycle.
- With MAX_WAIT=N, the FSM enters FAULT on the edge after the (N+1)th consecutive not-ready cycle.

## Structure
- `chinpo_pkg` holds:
  - the state localparams;
  - opcode constants (OP_JR=3, OP_J=8, OP_BEQ=12, OP_JAL=11, OP_LW=14, OP_SW=15);
  - ALUOp codes (ADD=0, FUNC=2, PASS=3).
- One sub-module, `chinpo_wait_timer`. It holds the wait counter. Inputs: count enable, clear, MemReady. Output: timeout flag.

## Test plan
- Reset mid-LW_READ, then release with MemReady=1 and opcode 2: RESET → FETCH → DECODE → DR → WB. InstrDone high only in WB; RegWrite never pulses before WB.
- Opcode 12 with Branch=1: BEQ asserts PCWrite, 3-cycle instruction. With Branch=0: back to FETCH after DECODE, InstrDone=1 in DECODE.
- Opcode 14, MemReady low for 3 cycles in LW_READ, MAX_WAIT=15: MemRead held 4 cycles, then LW_WRITE with RegWrite=1, WriteDataSrc=1.
- Opcode 15, MemReady stuck at 0, MAX_WAIT=4: FAULT entered after 5 SW_WRITE cycles. Fault=1 persists until Reset, MemWrite=0 in FAULT.
- FETCH with Stall=1, MemReady=1 for 2 cycles: IRWrite=PCWrite=0 and the counter stays at 0. Once Stall drops, a single IRWrite/PCWrite pulse occurs.
- OPW=6, Opcode=20: DECODE goes to FAULT; opcode 3 goes JR → J with PcIn=1, and IR=4'b1010 drives MVA=1, CLRA=1 in JR.
